// File: rtl/ps2_mouse_init_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_init_ctrl_if
//  Description : Handshake bundle between the PS/2 mouse init controller and
//                its byte transmitter / receiver and host.
//                master : controller side (drives tx_valid/tx_data/status)
//                slave  : environment side (drives start, rx strobe, tx_ready)
//  Signals     : start        host request to (re)initialise
//                rx_valid     one-cycle strobe, rx_data holds received byte
//                rx_data[7:0] received PS/2 byte
//                tx_ready     transmitter accepts a byte this cycle
//                tx_valid     command byte offered
//                tx_data[7:0] command byte
//                stream_en    mouse is in stream mode
//                busy         init sequence in progress
//                error        init failed (sticky)
//                retry_count  retries consumed in current sequence
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_mouse_init_ctrl_if;
   logic       start;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       stream_en;
   logic       busy;
   logic       error;
   logic [1:0] retry_count;

   modport master (
      input  start, rx_valid, rx_data, tx_ready,
      output tx_valid, tx_data, stream_en, busy, error, retry_count
   );

   modport slave (
      output start, rx_valid, rx_data, tx_ready,
      input  tx_valid, tx_data, stream_en, busy, error, retry_count
   );
endinterface
`default_nettype wire

// File: rtl/ps2_mouse_init_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_init_ctrl
//  Description : Brings a PS/2 mouse into stream mode: sends Reset (FF),
//                waits for ACK (FA), BAT pass (AA) and the device ID, then
//                sends Enable Data Reporting (F4) and waits for its ACK.
//                Resend/failure bytes and wait-state timeouts trigger a
//                bounded number of retries before entering a sticky error.
//  Ports       : clk    clock, rising edge
//                reset  asynchronous, active-high
//                bus    ps2_mouse_init_ctrl_if.master (see interface file)
//  Parameters  : TIMEOUT   cycles allowed in a wait state (2 .. 2^24-1)
//                MAX_RETRY retries per sequence before error (0 .. 3)
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_mouse_init_ctrl #(
   parameter int TIMEOUT   = 1000000,
   parameter int MAX_RETRY = 3
) (
   input  wire logic                   clk,
   input  wire logic                   reset,
   ps2_mouse_init_ctrl_if.master       bus
);

   localparam logic [23:0] c_tmo_last  = 24'(TIMEOUT - 1);
   localparam logic [1:0]  c_max_retry = 2'(MAX_RETRY);
   localparam logic [7:0]  c_cmd_rst   = 8'hFF;
   localparam logic [7:0]  c_cmd_en    = 8'hF4;
   localparam logic [7:0]  c_rsp_ack   = 8'hFA;
   localparam logic [7:0]  c_rsp_rsnd  = 8'hFE;
   localparam logic [7:0]  c_rsp_bat   = 8'hAA;
   localparam logic [7:0]  c_rsp_batf  = 8'hFC;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_SEND_RST  = 4'd1,
      S_WAIT_ACK1 = 4'd2,
      S_WAIT_BAT  = 4'd3,
      S_WAIT_ID   = 4'd4,
      S_SEND_EN   = 4'd5,
      S_WAIT_ACK2 = 4'd6,
      S_STREAM    = 4'd7,
      S_ERROR     = 4'd8
   } state_t;

   state_t      r_state, w_state_nxt, w_reentry;
   logic [1:0]  r_retry, w_retry_nxt;
   logic [23:0] r_tmo_cnt, w_tmo_cnt_nxt;
   logic        w_tmo_hit, w_retry_evt;
   logic        r_tx_valid, w_tx_valid_nxt;
   logic [7:0]  r_tx_data, w_tx_data_nxt;
   logic        r_stream_en, r_busy, r_error;

   function automatic logic is_wait(state_t s);
      return (s == S_WAIT_ACK1) || (s == S_WAIT_BAT) ||
             (s == S_WAIT_ID)   || (s == S_WAIT_ACK2);
   endfunction

   // State, counters and all outputs are registered together; the outputs
   // are decoded from the next state so they line up with the state flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_retry     <= 2'd0;
         r_tmo_cnt   <= 24'd0;
         r_tx_valid  <= 1'b0;
         r_tx_data   <= 8'h00;
         r_stream_en <= 1'b0;
         r_busy      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_retry     <= w_retry_nxt;
         r_tmo_cnt   <= w_tmo_cnt_nxt;
         r_tx_valid  <= w_tx_valid_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_stream_en <= (w_state_nxt == S_STREAM);
         r_busy      <= w_tx_valid_nxt || is_wait(w_state_nxt);
         r_error     <= (w_state_nxt == S_ERROR);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry;
      w_retry_evt = 1'b0;
      w_reentry   = S_SEND_RST;
      // ">=" rather than "==" so a timeout masked by an ignored byte still
      // fires on the following cycle instead of waiting for counter wrap.
      w_tmo_hit   = (r_tmo_cnt >= c_tmo_last);

      case (r_state)
         S_IDLE, S_STREAM, S_ERROR: begin
            if (bus.start) begin
               w_state_nxt = S_SEND_RST;
               w_retry_nxt = 2'd0;
            end
         end
         S_SEND_RST: if (bus.tx_ready) w_state_nxt = S_WAIT_ACK1;
         S_SEND_EN:  if (bus.tx_ready) w_state_nxt = S_WAIT_ACK2;
         S_WAIT_ACK1: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == c_rsp_ack)       w_state_nxt = S_WAIT_BAT;
               else if (bus.rx_data == c_rsp_rsnd) w_retry_evt = 1'b1;
            end else if (w_tmo_hit) begin
               w_retry_evt = 1'b1;
            end
         end
         S_WAIT_BAT: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == c_rsp_bat)       w_state_nxt = S_WAIT_ID;
               else if (bus.rx_data == c_rsp_batf) w_retry_evt = 1'b1;
            end else if (w_tmo_hit) begin
               w_retry_evt = 1'b1;
            end
         end
         S_WAIT_ID: begin
            if (bus.rx_valid)   w_state_nxt = S_SEND_EN;
            else if (w_tmo_hit) w_retry_evt = 1'b1;
         end
         S_WAIT_ACK2: begin
            w_reentry = S_SEND_EN;
            if (bus.rx_valid) begin
               if (bus.rx_data == c_rsp_ack)       w_state_nxt = S_STREAM;
               else if (bus.rx_data == c_rsp_rsnd) w_retry_evt = 1'b1;
            end else if (w_tmo_hit) begin
               w_retry_evt = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_retry_evt) begin
         if (r_retry < c_max_retry) begin
            w_retry_nxt = r_retry + 2'd1;
            w_state_nxt = w_reentry;
         end else begin
            w_state_nxt = S_ERROR;
         end
      end

      // Counter runs only while remaining in the same wait state, so every
      // entry into a wait state starts from zero.
      if (is_wait(r_state) && (w_state_nxt == r_state))
         w_tmo_cnt_nxt = r_tmo_cnt + 24'd1;
      else
         w_tmo_cnt_nxt = 24'd0;

      w_tx_valid_nxt = (w_state_nxt == S_SEND_RST) || (w_state_nxt == S_SEND_EN);
      if (w_state_nxt == S_SEND_RST)     w_tx_data_nxt = c_cmd_rst;
      else if (w_state_nxt == S_SEND_EN) w_tx_data_nxt = c_cmd_en;
      else                               w_tx_data_nxt = 8'h00;
   end

   assign bus.tx_valid    = r_tx_valid;
   assign bus.tx_data     = r_tx_data;
   assign bus.stream_en   = r_stream_en;
   assign bus.busy        = r_busy;
   assign bus.error       = r_error;
   assign bus.retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_init_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_mouse_init_ctrl
//  Description : Self-checking bench for ps2_mouse_init_ctrl (TIMEOUT=16,
//                MAX_RETRY=3). A table-walk model of the init sequence gives
//                expected outputs every cycle; directed scenarios add
//                literal expectations on transfers, timing and status.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_mouse_init_ctrl;

   localparam int TIMEOUT   = 16;
   localparam int MAX_RETRY = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   ps2_mouse_init_ctrl_if bus ();

   ps2_mouse_init_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- model: walk through a fixed step list ----------------
   // steps 0..5: send FF, expect FA, expect AA, any ID, send F4, expect FA
   // -1 = idle, 6 = stream, 7 = error
   int m_step = -1, m_retries = 0, m_age = 0;

   function automatic bit step_is_send(int s); return s == 0 || s == 4; endfunction
   function automatic int good_byte(int s);
      case (s) 1: return 'hFA; 2: return 'hAA; 5: return 'hFA; default: return -1; endcase
   endfunction
   function automatic int bad_byte(int s);
      case (s) 1: return 'hFE; 2: return 'hFC; 5: return 'hFE; default: return -1; endcase
   endfunction
   function automatic int restart_step(int s); return (s == 5) ? 4 : 0; endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_step = -1; m_retries = 0; m_age = 0;
      end else if (bus.start && (m_step < 0 || m_step >= 6)) begin
         m_step = 0; m_retries = 0; m_age = 0;
      end else if (m_step >= 0 && m_step <= 5) begin
         if (step_is_send(m_step)) begin
            if (bus.tx_ready) begin m_step = m_step + 1; m_age = 0; end
         end else begin
            bit adv, rty;
            adv = 0; rty = 0;
            if (bus.rx_valid) begin
               if (m_step == 3 || int'(bus.rx_data) == good_byte(m_step)) adv = 1;
               else if (int'(bus.rx_data) == bad_byte(m_step)) rty = 1;
            end else if (m_age >= TIMEOUT - 1) rty = 1;
            if (adv) begin
               m_step = m_step + 1; m_age = 0;
            end else if (rty) begin
               if (m_retries < MAX_RETRY) begin
                  m_retries = m_retries + 1; m_step = restart_step(m_step);
               end else m_step = 7;
               m_age = 0;
            end else m_age = m_age + 1;
         end
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge clk) begin
      if (!reset) begin
         logic       e_txv, e_busy, e_str, e_err;
         logic [7:0] e_txd;
         logic [1:0] e_rc;
         e_txv  = step_is_send(m_step);
         e_txd  = (m_step == 0) ? 8'hFF : 8'hF4;
         e_busy = (m_step >= 0 && m_step <= 5);
         e_str  = (m_step == 6);
         e_err  = (m_step == 7);
         e_rc   = 2'(m_retries);
         total++;
         if (bus.tx_valid !== e_txv || bus.busy !== e_busy || bus.stream_en !== e_str ||
             bus.error !== e_err || bus.retry_count !== e_rc ||
             (e_txv && bus.tx_data !== e_txd)) begin
            bad++;
            $display("FAIL model_cycle%0d: got txv=%b txd=%h busy=%b str=%b err=%b rc=%0d want txv=%b txd=%h busy=%b str=%b err=%b rc=%0d",
                     cyc, bus.tx_valid, bus.tx_data, bus.busy, bus.stream_en, bus.error,
                     bus.retry_count, e_txv, e_txd, e_busy, e_str, e_err, e_rc);
         end
      end
   end

   // ---------------- transfer recorder ----------------
   logic [7:0] xfer_q[$];
   int         xfer_cyc[$];
   always @(negedge clk) begin
      if (!reset && bus.tx_valid && bus.tx_ready) begin
         xfer_q.push_back(bus.tx_data);
         xfer_cyc.push_back(cyc);
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick(); @(posedge clk); #2; endtask

   task automatic do_start(); bus.start = 1'b1; tick(); bus.start = 1'b0; endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1; bus.rx_data = b; tick(); bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
   endtask

   task automatic clear_xfers(); xfer_q.delete(); xfer_cyc.delete(); endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b1;
      #1 reset = 1'b1;
      #1;
      check("reset_outputs", {bus.tx_valid, bus.tx_data, bus.stream_en, bus.busy, bus.error, bus.retry_count}, 32'd0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      repeat (3) tick();
      check("idle_after_reset", {bus.busy, bus.tx_valid, bus.stream_en, bus.error}, 4'b0000);

      // Nominal bring-up, with one ignored byte in WAIT_ACK1
      clear_xfers();
      do_start();
      check("start_sends_ff", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hFF});
      tick();
      send_byte(8'h55);
      send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
      tick();
      send_byte(8'hFA);
      tick();
      check("nom_xfer_count", xfer_q.size(), 2);
      if (xfer_q.size() == 2) begin
         check("nom_xfer0", xfer_q[0], 8'hFF);
         check("nom_xfer1", xfer_q[1], 8'hF4);
      end
      check("nom_status", {bus.stream_en, bus.busy, bus.error, bus.retry_count}, 5'b10000);

      // Resend in WAIT_ACK1 and in WAIT_ACK2
      clear_xfers();
      do_start();
      tick();
      send_byte(8'hFE);
      tick();
      send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h03);
      tick();
      send_byte(8'hFE);
      tick();
      send_byte(8'hFA);
      tick();
      check("rsnd_xfer_count", xfer_q.size(), 4);
      if (xfer_q.size() == 4)
         check("rsnd_seq", {xfer_q[0], xfer_q[1], xfer_q[2], xfer_q[3]}, 32'hFFFFF4F4);
      check("rsnd_status", {bus.stream_en, bus.retry_count}, 3'b110);

      // Timeout exhaustion
      clear_xfers();
      do_start();
      repeat (70) tick();
      check("tmo_xfer_count", xfer_q.size(), 4);
      if (xfer_q.size() == 4) begin
         for (int i = 1; i < 4; i++)
            check($sformatf("tmo_gap%0d", i), xfer_cyc[i] - xfer_cyc[i-1], 1 + TIMEOUT);
      end
      check("tmo_error", {bus.error, bus.busy, bus.retry_count}, 4'b1011);
      do_start();
      check("restart_after_error", {bus.error, bus.tx_valid, bus.tx_data, bus.retry_count}, {1'b0, 1'b1, 8'hFF, 2'd0});

      // Collision: FA on the last cycle of WAIT_ACK1
      tick();
      repeat (TIMEOUT - 1) tick();
      send_byte(8'hFA);
      repeat (2) tick();
      check("collision_status", {bus.busy, bus.tx_valid, bus.retry_count, bus.error}, 5'b10000);

      // Reset while in WAIT_BAT
      reset = 1'b1; bus.start = 1'b1;
      #1;
      check("async_reset_outputs", {bus.tx_valid, bus.tx_data, bus.stream_en, bus.busy, bus.error, bus.retry_count}, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      check("start_ignored_in_reset", {bus.busy, bus.tx_valid}, 2'b00);
      reset = 1'b0; bus.start = 1'b0;
      tick();
      check("idle_after_reset2", bus.busy, 1'b0);

      // Backpressure in SEND_RST
      bus.tx_ready = 1'b0;
      do_start();
      repeat (100) tick();
      check("bp_hold", {bus.tx_valid, bus.tx_data, bus.busy, bus.retry_count}, {1'b1, 8'hFF, 1'b1, 2'd0});
      bus.tx_ready = 1'b1;
      tick();
      check("bp_release", {bus.tx_valid, bus.busy}, 2'b01);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
